// File: rtl/nfault_pkg.sv
// rtl/nfault_pkg.sv - shared types and defaults for the nFault line driver
package nfault_pkg;

    typedef enum logic [1:0] {
        S_N0 = 2'd0,  // released: line at 'z
        S_N1 = 2'd1,  // asserting: minimum-width pulse in progress
        S_N2 = 2'd2   // holding: line low until released or no fault pending
    } nfault_state_t;

    localparam int DEF_NUM_FAULT_SRC     = 8;
    localparam int DEF_FILTER_CYCLES     = 4;
    localparam int DEF_MIN_ASSERT_CYCLES = 50;

    // Width of the min-width down-counter; never narrower than one bit.
    function automatic int min_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/fault_input_filter.sv
// rtl/fault_input_filter.sv - per-source glitch filter with sticky latch and clear
module fault_input_filter
    import nfault_pkg::*;
#(
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic fault_in,
    input  logic fault_clear,
    output logic fault_latched
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Count consecutive high samples; latch on reaching the limit, clear wins over latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            fault_latched <= 1'b0;
        end else if (fault_clear) begin
            cnt           <= '0;
            fault_latched <= 1'b0;
        end else if (!fault_in) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
                fault_latched <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/nfault_line_driver.sv
// rtl/nfault_line_driver.sv - nFault open-drain driver FSM; NFAULT_LINE_SENSE_EN adds line read-back
module nfault_line_driver
    import nfault_pkg::*;
#(
    parameter int NUM_FAULT_SRC     = DEF_NUM_FAULT_SRC,
    parameter int FILTER_CYCLES     = DEF_FILTER_CYCLES,
    parameter int MIN_ASSERT_CYCLES = DEF_MIN_ASSERT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     set_nFault_value,
    input  logic                     set_nFault_z,
    input  logic [NUM_FAULT_SRC-1:0] fault_in,
    input  logic [NUM_FAULT_SRC-1:0] fault_mask,
    input  logic                     fault_clear,
    inout  wire                      nFault,
    output logic [NUM_FAULT_SRC-1:0] fault_latched,
    output logic                     fault_pending,
    output logic                     nFault_asserted,
    output logic                     nFault_external
);

    localparam int MCW = min_cnt_width(MIN_ASSERT_CYCLES);
    localparam logic [MCW-1:0] MIN_LOAD = MCW'(MIN_ASSERT_CYCLES - 1);

    nfault_state_t  state;
    logic [MCW-1:0] min_cnt;
    logic           release_req;

    for (genvar i = 0; i < NUM_FAULT_SRC; i++) begin : g_filter
        fault_input_filter #(
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_filter (
            .clk          (clk),
            .reset        (reset),
            .fault_in     (fault_in[i]),
            .fault_clear  (fault_clear),
            .fault_latched(fault_latched[i])
        );
    end

    assign fault_pending = |(fault_latched & ~fault_mask);

    // Line FSM: minimum-width pulse, then hold; release requests seen mid-pulse are remembered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_N0;
            min_cnt         <= '0;
            release_req     <= 1'b0;
            nFault_asserted <= 1'b0;
        end else begin
            case (state)
                S_N0: begin
                    if (set_nFault_value && !set_nFault_z && fault_pending) begin
                        state           <= S_N1;
                        min_cnt         <= MIN_LOAD;
                        release_req     <= 1'b0;
                        nFault_asserted <= 1'b1;
                    end
                end
                S_N1: begin
                    if (min_cnt == '0) begin
                        release_req <= 1'b0;
                        if (release_req || set_nFault_z || !fault_pending) begin
                            state           <= S_N0;
                            nFault_asserted <= 1'b0;
                        end else begin
                            state <= S_N2;
                        end
                    end else begin
                        min_cnt <= min_cnt - MCW'(1);
                        if (set_nFault_z) begin
                            release_req <= 1'b1;
                        end
                    end
                end
                S_N2: begin
                    if (set_nFault_z || !fault_pending) begin
                        state           <= S_N0;
                        nFault_asserted <= 1'b0;
                    end
                end
                default: begin
                    state           <= S_N0;
                    release_req     <= 1'b0;
                    nFault_asserted <= 1'b0;
                end
            endcase
        end
    end

    assign nFault = nFault_asserted ? 1'b0 : 1'bz;

`ifdef NFAULT_LINE_SENSE_EN
    logic [1:0] line_low_sync;

    // Synchronise the line and flag a low level that this block is not causing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_low_sync   <= 2'b00;
            nFault_external <= 1'b0;
        end else begin
            line_low_sync   <= {line_low_sync[0], ~nFault};
            nFault_external <= line_low_sync[1] && (state == S_N0);
        end
    end
`else
    assign nFault_external = 1'b0;
`endif

endmodule

// File: doc/nfault_line_driver.md
# nfault_line_driver

Downstream stage of the nFault error-processing FSM. It consumes that FSM's `set_nFault_value` / `set_nFault_z` Moore strobes, filters and latches per-subsystem fault inputs, and drives the shared open-drain nFault board line: pulled low, or released to 'z'. It guarantees a minimum assertion width and exposes sticky fault status to the register bus.

## Interface
Parameters:
- `NUM_FAULT_SRC`, default 8: number of fault sources.
- `FILTER_CYCLES`, default 4: consecutive high samples required to latch a fault (≥1).
- `MIN_ASSERT_CYCLES`, default 50: minimum nFault low time in clk cycles (≥1); 1 µs at 50 MHz.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: reset, asynchronous, active-low.
- `set_nFault_value`  in  1: one-cycle strobe; drive nFault if an unmasked fault is latched.
- `set_nFault_z`  in  1: one-cycle strobe; release nFault.
- `fault_in`  in  NUM_FAULT_SRC: raw fault flags, synchronous to clk.
- `fault_mask`  in  NUM_FAULT_SRC: 1 = source excluded from nFault decision (still latched).
- `fault_clear`  in  1: one-cycle strobe; clear all latched faults.
- `nFault`  inout  1: board line; 1'b0 when driving, 'z otherwise; external pull-up.
- `fault_latched`  out  NUM_FAULT_SRC: sticky filtered fault bits.
- `fault_pending`  out  1: |(fault_latched & ~fault_mask).
- `nFault_asserted`  out  1: 1 while the block drives nFault low.
- `nFault_external`  out  1: line low while not driven by this block (see Configuration).

## Operation
- Filter, one per source: counter saturates at FILTER_CYCLES and increments while `fault_in` = 1. It resets to 0 when `fault_in` = 0. The latched bit sets on the edge where the counter reaches FILTER_CYCLES and is sticky.
- `fault_clear` zeroes every latched bit and every filter counter in the same edge; clear wins over a simultaneous latch. A still-high input re-latches after FILTER_CYCLES more cycles.
- FSM states:
  - S_N0 RELEASED: nFault 'z. Goes to S_N1 on `set_nFault_value` && `fault_pending`; otherwise stays. `set_nFault_z` here is a no-op.
  - S_N1 ASSERT: nFault 0. Min-width counter loaded with MIN_ASSERT_CYCLES-1 on entry, decrements each cycle. At 0, goes to S_N0 if `release_req` is set or `fault_pending` = 0; else goes to S_N2.
  - S_N2 HOLD: nFault 0. Goes to S_N0 on `set_nFault_z` or when `fault_pending` = 0; `set_nFault_value` keeps it in S_N2.
- `release_req`: set by `set_nFault_z` in S_N1, cleared on S_N1 exit. A release is therefore never lost and never shortens the pulse.
- Simultaneous `set_nFault_z` and `set_nFault_value`: z wins (S_N0 stays; S_N2 goes to S_N0; in S_N1, `release_req` is set).
- Masking a source mid-assert drops `fault_pending`. The release is taken in S_N2, or at the end of S_N1.
- Illegal state encoding: next state is S_N0.

## Timing
- Reset values: state S_N0, nFault 'z, `fault_latched` 0, counters 0, `release_req` 0, `fault_pending`/`nFault_asserted`/`nFault_external` 0.
- Reset asserted mid-assert releases nFault immediately (asynchronous).
- Moore outputs: `nFault` and `nFault_asserted` are decoded from state only.
- `set_nFault_value` sampled at edge k puts nFault low from edge k onward. The low time is ≥MIN_ASSERT_CYCLES cycles.
- Latch latency: `fault_in` high from edge 0 gives `fault_latched` high after edge FILTER_CYCLES-1, i.e. FILTER_CYCLES samples.
- `fault_pending` is combinational from registers and `fault_mask`.

## Configuration
- `NFAULT_LINE_SENSE_EN` defined:
  - nFault is read back through a 2-FF synchroniser.
  - `nFault_external` = synchronised line low && state == S_N0. It is registered and asserts 2–3 cycles after another board pulls the line low.
  - The synchroniser is cleared by reset.
- Not defined: no synchroniser; `nFault_external` tied to 0.

## Structure
- Shared package `nfault_pkg`: `nfault_state_t` enum {S_N0, S_N1, S_N2} (2-bit), default parameter constants, MIN-counter width via $clog2(MIN_ASSERT_CYCLES).
- Sub-module `fault_input_filter` (counter + sticky bit + clear), instantiated NUM_FAULT_SRC times by generate.
- Top holds the FSM, min-width counter, `release_req`, tri-state assign and the optional sense logic.

## Test plan
- `fault_in[3]` high for 3 cycles then low (FILTER=4) → `fault_latched` stays 0. Held 4 cycles → `fault_latched` = 8'h08, latched after `fault_in` falls.
- Latched `fault[0]`, `set_nFault_value` pulse → nFault 0 next cycle. `set_nFault_z` at cycle 10 → nFault stays 0 until exactly 50 cycles, then 'z.
- `set_nFault_value` with `fault_pending` = 0 → nFault remains 'z, state S_N0.
- In S_N2, `fault_mask` = 8'h01 while only `fault[0]` is latched → nFault 'z next cycle. `fault_clear` with `fault_in[0]` still high → `fault_latched` 0, re-set 4 cycles later.
- Simultaneous `set_nFault_z` + `set_nFault_value` in S_N2 → release. Reset pulse in S_N1 → nFault 'z asynchronously, all outputs 0.
- With `NFAULT_LINE_SENSE_EN`, external driver pulls nFault low in S_N0 → `nFault_external` = 1 within 3 cycles. Pulled low in S_N2 → stays 0.
